hazard_unit_mc: RTL and testbench
=================================

// Module: hazard_unit_mc
// PURPOSE
//   Parametrised pipeline hazard unit for the 5-stage ARM core (F/D/E/M/W).
//   Generalises forwarding and load-use detection to NUM_SRC source operands (Rn, Rm, Rs).
//   Adds a multicycle-execute FSM that holds E for MC_LAT cycles on long/multiply ops.
//   Generates all stall and flush controls; sits beside controller and datapath in arm.
// PARAMETERS
//   NUM_SRC  3  source-register operands checked per instruction
//   REG_AW   4  register address width; address all-ones (R15/PC) is never forwarded
//   MC_LAT   4  E-stage occupancy in cycles for LongE ops (>=1; 1 = no stall)
// PORTS
//   clk          in   1                clock, rising edge
//   reset        in   1                synchronous, active-high
//   RA_D         in   NUM_SRC*REG_AW   D-stage source regs; src i at [i*REG_AW +: REG_AW]
//   SrcValidD    in   NUM_SRC          per-source valid mask for RA_D
//   RA_E         in   NUM_SRC*REG_AW   E-stage source regs, same packing
//   SrcValidE    in   NUM_SRC          per-source valid mask for RA_E
//   WA_E/WA_M/WA_W in REG_AW           destination reg in E/M/W
//   RegWriteM, RegWriteW  in  1        register write enable in M/W
//   MemToRegE    in   1                E-stage instruction is a load
//   LongE        in   1                E-stage instruction is multicycle
//   PCSrcD/E/M/W in   1                PC-writing instruction present in that stage
//   BranchTakenE in   1                branch resolved taken in E
//   ForwardE     out  2*NUM_SRC        per-source select, [2*i +: 2]: 00 RF, 10 ALUOutM, 01 ResultW
//   StallF, StallD, StallE  out 1      hold F/D/E pipeline registers
//   FlushD, FlushE, FlushM  out 1      bubble D/E/M pipeline registers
//   MCBusy       out  1                multicycle stall active this cycle
// BEHAVIOUR
//   All outputs combinational from inputs + FSM state; only state is {mc_state, mc_cnt}.
//   reset high: mc_state<=IDLE, mc_cnt<=0; outputs forced: ForwardE=0, Stall*=0, MCBusy=0,
//     FlushD=FlushE=FlushM=1. Reset mid-multicycle aborts the op immediately.
//   Forwarding, per source i (SrcValidE[i]=0 or RA_E[i]=all-ones -> 00):
//     RegWriteM & WA_M==RA_E[i] -> 10; else RegWriteW & WA_W==RA_E[i] -> 01; else 00.
//     M has priority over W when both match.
//   ldrstall = MemToRegE & OR_i(SrcValidD[i] & RA_D[i]==WA_E).
//   pcpend = PCSrcD|PCSrcE|PCSrcM.
//   Multicycle FSM, states IDLE/BUSY, mc_cnt width clog2(MC_LAT)+1:
//     IDLE & LongE & MC_LAT>1: mcstall=1, next BUSY, mc_cnt<=MC_LAT-2.
//     BUSY & mc_cnt!=0: mcstall=1, mc_cnt<=mc_cnt-1.
//     BUSY & mc_cnt==0: mcstall=0, next IDLE.
//     Result: the op occupies E for exactly MC_LAT cycles, with MC_LAT-1 stall cycles.
//     The release cycle is in BUSY, so a held LongE never re-triggers.
//     Back-to-back LongE ops each take a full MC_LAT cycles.
//   MCBusy = mcstall; StallE = mcstall; FlushM = mcstall (bubbles into M; older instrs drain).
//   StallF = ldrstall | mcstall | pcpend.   StallD = ldrstall | mcstall.
//   FlushD = pcpend | PCSrcW | BranchTakenE (flush overrides StallD; D holds wrong-path only).
//   FlushE = (ldrstall | BranchTakenE) & ~mcstall (E is never flushed while held).
//   ForwardE is evaluated every cycle, including during mcstall.
//     Drained bubbles have RegWrite=0, so selects fall back to 00 (RF already written).
//   Invariant (assert in TB): LongE & (BranchTakenE | MemToRegE | PCSrcW) never true.
// TESTING
//   1. RA_E src0=3, WA_M=3, RegWriteM=1, WA_W=3, RegWriteW=1 -> ForwardE[1:0]=10.
//      Set RA_E src1=15 with WA_M=15 -> ForwardE[3:2]=00.
//   2. MemToRegE=1, WA_E=5, RA_D src1=5, SrcValidD=3'b010 -> StallF=StallD=FlushE=1 for one cycle.
//      Same case with SrcValidD=3'b000 -> all stall/flush outputs 0.
//   3. MC_LAT=4, LongE held 4 cycles -> MCBusy=StallE=FlushM=1 in cycles 0-2, 0 in cycle 3.
//      FSM is IDLE in cycle 4.
//   4. Two LongE ops back-to-back (LongE high 8 cycles) -> MCBusy pattern 1110_1110.
//      MC_LAT=1 build -> MCBusy stays 0.
//   5. BranchTakenE=1 -> FlushD=FlushE=1, StallF=0.
//      PCSrcM=1 -> StallF=1, FlushD=1, FlushE=0.
//   6. Assert reset in cycle 1 of a MC_LAT=4 op -> MCBusy=0 while reset is high.
//      Next LongE after reset restarts a full 3-cycle stall.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Pipeline hazard unit for the 5-stage core: per-source forwarding selects,
// load-use detection, PC-write hazards, and a multicycle-execute hold FSM.
//
//   state | meaning
//   IDLE  | no multicycle op in E; a LongE op arriving here starts a hold
//   BUSY  | multicycle op held in E; mc_cnt counts remaining stall cycles
module hazard_unit_mc #(
  parameter int NUM_SRC = 3,
  parameter int REG_AW  = 4,
  parameter int MC_LAT  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC*REG_AW-1:0]   RA_D,
  input  logic [NUM_SRC-1:0]          SrcValidD,
  input  logic [NUM_SRC*REG_AW-1:0]   RA_E,
  input  logic [NUM_SRC-1:0]          SrcValidE,
  input  logic [REG_AW-1:0]           WA_E,
  input  logic [REG_AW-1:0]           WA_M,
  input  logic [REG_AW-1:0]           WA_W,
  input  logic                        RegWriteM,
  input  logic                        RegWriteW,
  input  logic                        MemToRegE,
  input  logic                        LongE,
  input  logic                        PCSrcD,
  input  logic                        PCSrcE,
  input  logic                        PCSrcM,
  input  logic                        PCSrcW,
  input  logic                        BranchTakenE,
  output logic [2*NUM_SRC-1:0]        ForwardE,
  output logic                        StallF,
  output logic                        StallD,
  output logic                        StallE,
  output logic                        FlushD,
  output logic                        FlushE,
  output logic                        FlushM,
  output logic                        MCBusy
);

  localparam int CW = $clog2(MC_LAT) + 1;
  // First loaded count; the entry cycle itself is one of the stall cycles.
  localparam int INIT_I = (MC_LAT > 1) ? (MC_LAT - 2) : 0;
  localparam logic [CW-1:0] MC_INIT = INIT_I[CW-1:0];
  localparam logic [REG_AW-1:0] PC_REG = {REG_AW{1'b1}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mc_state_t;

  mc_state_t mc_state, mc_state_next;
  logic [CW-1:0] mc_cnt, mc_cnt_next;
  logic mcstall;
  logic ldrstall;
  logic pcpend;
  logic [2*NUM_SRC-1:0] fwd;

  // Multicycle state register; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      mc_state <= IDLE;
      mc_cnt   <= '0;
    end else begin
      mc_state <= mc_state_next;
      mc_cnt   <= mc_cnt_next;
    end
  end

  // Multicycle next-state: the release cycle stays in BUSY so a held LongE
  // is not mistaken for a new op.
  always_comb begin
    mc_state_next = mc_state;
    mc_cnt_next   = mc_cnt;
    mcstall       = 1'b0;
    case (mc_state)
      IDLE: begin
        if (LongE && (MC_LAT > 1)) begin
          mcstall       = 1'b1;
          mc_state_next = BUSY;
          mc_cnt_next   = MC_INIT;
        end
      end
      BUSY: begin
        if (mc_cnt != '0) begin
          mcstall     = 1'b1;
          mc_cnt_next = mc_cnt - 1'b1;
        end else begin
          mc_state_next = IDLE;
        end
      end
      default: mc_state_next = IDLE;
    endcase
  end

  // Per-source forwarding select (M beats W) and load-use detection.
  always_comb begin
    fwd      = '0;
    ldrstall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SrcValidE[i] && (RA_E[i*REG_AW +: REG_AW] != PC_REG)) begin
        if (RegWriteM && (WA_M == RA_E[i*REG_AW +: REG_AW]))
          fwd[2*i +: 2] = 2'b10;
        else if (RegWriteW && (WA_W == RA_E[i*REG_AW +: REG_AW]))
          fwd[2*i +: 2] = 2'b01;
      end
      if (MemToRegE && SrcValidD[i] && (RA_D[i*REG_AW +: REG_AW] == WA_E))
        ldrstall = 1'b1;
    end
  end

  assign pcpend = PCSrcD | PCSrcE | PCSrcM;

  // Stall/flush outputs; reset forces a bubbled, unstalled pipeline.
  always_comb begin
    if (reset) begin
      ForwardE = '0;
      StallF   = 1'b0;
      StallD   = 1'b0;
      StallE   = 1'b0;
      MCBusy   = 1'b0;
      FlushD   = 1'b1;
      FlushE   = 1'b1;
      FlushM   = 1'b1;
    end else begin
      ForwardE = fwd;
      StallF   = ldrstall | mcstall | pcpend;
      StallD   = ldrstall | mcstall;
      StallE   = mcstall;
      MCBusy   = mcstall;
      FlushD   = pcpend | PCSrcW | BranchTakenE;
      // E is never bubbled while it holds a multicycle op.
      FlushE   = (ldrstall | BranchTakenE) & ~mcstall;
      // Bubbles enter M while older instructions drain.
      FlushM   = mcstall;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: forwarding, load-use, PC hazards,
// multicycle hold timing (MC_LAT=4 and MC_LAT=1), and reset abort.
module tb_hazard_unit_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] RA_D, RA_E;
  logic [2:0]  SrcValidD, SrcValidE;
  logic [3:0]  WA_E, WA_M, WA_W;
  logic        RegWriteM, RegWriteW, MemToRegE, LongE;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic [5:0]  ForwardE, ForwardE1;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MCBusy;
  logic        StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, MCBusy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.NUM_SRC(3), .REG_AW(4), .MC_LAT(4)) dut (
    .clk(clk), .reset(reset), .RA_D(RA_D), .SrcValidD(SrcValidD),
    .RA_E(RA_E), .SrcValidE(SrcValidE), .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
    .LongE(LongE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .ForwardE(ForwardE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
    .FlushE(FlushE), .FlushM(FlushM), .MCBusy(MCBusy)
  );

  hazard_unit_mc #(.NUM_SRC(3), .REG_AW(4), .MC_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .RA_D(RA_D), .SrcValidD(SrcValidD),
    .RA_E(RA_E), .SrcValidE(SrcValidE), .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
    .LongE(LongE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .ForwardE(ForwardE1),
    .StallF(StallF1), .StallD(StallD1), .StallE(StallE1), .FlushD(FlushD1),
    .FlushE(FlushE1), .FlushM(FlushM1), .MCBusy(MCBusy1)
  );

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,MCBusy}
  wire [6:0] ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MCBusy};

  // Stimulus must never combine a multicycle op with these E/W events.
  always @(negedge clk)
    if (!reset)
      assert (!(LongE && (BranchTakenE || MemToRegE || PCSrcW)))
        else $error("invariant violated: LongE with branch/load/PCSrcW");

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    RA_D = '0; RA_E = '0; SrcValidD = '0; SrcValidE = '0;
    WA_E = '0; WA_M = '0; WA_W = '0;
    RegWriteM = 0; RegWriteW = 0; MemToRegE = 0; LongE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
  endtask

  // Advance one cycle: inputs change just after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One multicycle-test cycle: drive LongE/reset, check at the falling edge.
  task automatic mc_cycle(input string tag, input logic long_in, input logic rst_in,
                          input logic exp_busy);
    LongE = long_in;
    reset = rst_in;
    @(negedge clk);
    chk(tag, {31'd0, MCBusy}, {31'd0, exp_busy});
    chk({tag, "_lat1"}, {31'd0, MCBusy1}, 32'd0);
    next_cycle();
  endtask

  logic [7:0] pat;

  initial begin
    clear_inputs();
    reset = 1'b1;
    // Reset state, with forwarding-matching inputs present.
    RA_E = {4'd0, 4'd0, 4'd3}; SrcValidE = 3'b111; WA_M = 4'd3; RegWriteM = 1;
    @(negedge clk);
    chk("rst_ctl", {25'd0, ctl}, {25'd0, 7'b0001110});
    chk("rst_fwd", {26'd0, ForwardE}, 32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    clear_inputs();

    // Forwarding vectors.
    RA_E = {4'd0, 4'd0, 4'd3}; SrcValidE = 3'b111;
    WA_M = 4'd3; RegWriteM = 1; WA_W = 4'd3; RegWriteW = 1;
    @(negedge clk);
    chk("fwd_m_prio", {26'd0, ForwardE}, {26'd0, 6'b000010});
    chk("fwd_ctl_idle", {25'd0, ctl}, 32'd0);
    RA_E = {4'd0, 4'd15, 4'd3}; WA_M = 4'd15;
    @(negedge clk);
    chk("fwd_r15", {26'd0, ForwardE}, {26'd0, 6'b000001});
    RA_E = {4'd7, 4'd2, 4'd2}; WA_M = 4'd7; WA_W = 4'd2;
    @(negedge clk);
    chk("fwd_mixed", {26'd0, ForwardE}, {26'd0, 6'b100101});
    SrcValidE = 3'b010;
    @(negedge clk);
    chk("fwd_valid_mask", {26'd0, ForwardE}, {26'd0, 6'b000100});
    RA_E = {4'd2, 4'd2, 4'd2}; SrcValidE = 3'b101; WA_M = 4'd2; RegWriteW = 0;
    @(negedge clk);
    chk("fwd_m_only", {26'd0, ForwardE}, {26'd0, 6'b100010});
    RegWriteM = 0;
    @(negedge clk);
    chk("fwd_no_write", {26'd0, ForwardE}, 32'd0);
    clear_inputs();

    // Load-use.
    MemToRegE = 1; WA_E = 4'd5; RA_D = {4'd0, 4'd5, 4'd0}; SrcValidD = 3'b010;
    @(negedge clk);
    chk("ldr_stall", {25'd0, ctl}, {25'd0, 7'b1100100});
    SrcValidD = 3'b000;
    @(negedge clk);
    chk("ldr_invalid", {25'd0, ctl}, 32'd0);
    RA_D = {4'd0, 4'd0, 4'd5}; SrcValidD = 3'b010;
    @(negedge clk);
    chk("ldr_other_src", {25'd0, ctl}, 32'd0);
    MemToRegE = 0; RA_D = {4'd0, 4'd5, 4'd0};
    @(negedge clk);
    chk("ldr_not_load", {25'd0, ctl}, 32'd0);
    clear_inputs();

    // Branch / PC-write hazards.
    BranchTakenE = 1;
    @(negedge clk);
    chk("br_taken", {25'd0, ctl}, {25'd0, 7'b0001100});
    BranchTakenE = 0; PCSrcM = 1;
    @(negedge clk);
    chk("pcsrc_m", {25'd0, ctl}, {25'd0, 7'b1001000});
    PCSrcM = 0; PCSrcD = 1;
    @(negedge clk);
    chk("pcsrc_d", {25'd0, ctl}, {25'd0, 7'b1001000});
    PCSrcD = 0; PCSrcW = 1;
    @(negedge clk);
    chk("pcsrc_w", {25'd0, ctl}, {25'd0, 7'b0001000});
    clear_inputs();
    next_cycle();

    // Single multicycle op, LongE held for exactly MC_LAT cycles.
    LongE = 1;
    @(negedge clk);
    chk("mc_ctl", {25'd0, ctl}, {25'd0, 7'b1110011});
    next_cycle();
    mc_cycle("mc1_c1", 1, 0, 1);
    mc_cycle("mc1_c2", 1, 0, 1);
    mc_cycle("mc1_c3", 1, 0, 0);
    mc_cycle("mc1_c4_idle", 0, 0, 0);
    LongE = 1;
    @(negedge clk);
    chk("mc_idle_restart", {31'd0, MCBusy}, 32'd1);
    next_cycle();
    mc_cycle("mc_drain1", 0, 0, 1);
    mc_cycle("mc_drain2", 0, 0, 1);
    mc_cycle("mc_drain3", 0, 0, 0);
    mc_cycle("mc_drain4", 0, 0, 0);

    // Back-to-back ops: LongE high for 8 cycles -> 1110_1110.
    pat = 8'b1110_1110;
    for (int c = 0; c < 8; c++)
      mc_cycle($sformatf("b2b_c%0d", c), 1, 0, pat[7-c]);
    mc_cycle("b2b_after", 0, 0, 0);

    // Reset during cycle 1 of an op aborts it; next op gets a full stall.
    mc_cycle("rst_op_c0", 1, 0, 1);
    mc_cycle("rst_op_c1", 1, 1, 0);
    mc_cycle("rst_new_c0", 1, 0, 1);
    mc_cycle("rst_new_c1", 1, 0, 1);
    mc_cycle("rst_new_c2", 1, 0, 1);
    mc_cycle("rst_new_c3", 1, 0, 0);
    mc_cycle("rst_new_idle", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
